// File: rtl/dbi_init_seq.sv
// rtl/dbi_init_seq.sv - DBI panel power-up command sequencer driving a type/command/data transaction port.
// Optional: define DBI_INIT_AUTO_START_EN to launch the sequence on the first cycle after reset.
module dbi_init_seq #(
  parameter int INTERNAL_CLK = 125000000,
  parameter int DBI_IF_D_W   = 8,
  parameter int SLP_WAIT_CYC = 750000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  tx_type_rdy_i,
  input  logic                  tx_com_rdy_i,
  input  logic                  tx_data_rdy_i,
  output logic [1:0]            dbi_ctrl_mode_o,
  output logic [DBI_IF_D_W-1:0] dbi_mem_com_o,
  output logic                  tx_type_rw_o,
  output logic                  tx_type_hrst_o,
  output logic [2:0]            tx_type_dat_amt_o,
  output logic                  tx_type_vld_o,
  output logic [DBI_IF_D_W-1:0] tx_com_o,
  output logic                  tx_com_vld_o,
  output logic [DBI_IF_D_W-1:0] tx_data_o,
  output logic                  tx_data_vld_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CNT_W = $clog2(SLP_WAIT_CYC + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CMD      = 2'd1;
  localparam logic [1:0] ST_SLP_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  localparam logic [2:0] SLP_ENT      = 3'd1;
  localparam logic [2:0] POST_SLP_ENT = 3'd2;
  localparam logic [2:0] LAST_ENT     = 3'd6;

  localparam logic [CNT_W-1:0] SLP_LOAD = CNT_W'(SLP_WAIT_CYC - 1);

  logic [1:0]       state;
  logic [2:0]       ent_idx;
  logic [2:0]       byte_idx;
  logic [CNT_W-1:0] slp_cnt;

  logic        ent_hrst;
  logic [7:0]  ent_com;
  logic [2:0]  ent_amt;
  logic [31:0] ent_bytes;
  logic [7:0]  ent_byte;

  logic in_cmd;
  logic data_vld;
  logic type_hs;
  logic data_hs;
  logic start_go;

  // Init table: payload bytes are packed first-byte-in-MSB.
  always_comb begin
    ent_hrst  = 1'b0;
    ent_com   = 8'h00;
    ent_amt   = 3'd0;
    ent_bytes = 32'h0000_0000;
    case (ent_idx)
      3'd0: ent_hrst = 1'b1;
      3'd1: ent_com  = 8'h11;
      3'd2: begin ent_com = 8'h3A; ent_amt = 3'd1; ent_bytes = 32'h5500_0000; end
      3'd3: begin ent_com = 8'h36; ent_amt = 3'd1; ent_bytes = 32'h4800_0000; end
      3'd4: begin ent_com = 8'h2A; ent_amt = 3'd4; ent_bytes = 32'h0000_00EF; end
      3'd5: begin ent_com = 8'h2B; ent_amt = 3'd4; ent_bytes = 32'h0000_013F; end
      3'd6: ent_com  = 8'h29;
      default: ent_com = 8'h00;
    endcase
  end

  always_comb begin
    ent_byte = 8'h00;
    case (byte_idx[1:0])
      2'd0: ent_byte = ent_bytes[31:24];
      2'd1: ent_byte = ent_bytes[23:16];
      2'd2: ent_byte = ent_bytes[15:8];
      default: ent_byte = ent_bytes[7:0];
    endcase
  end

  assign in_cmd   = (state == ST_CMD);
  assign data_vld = in_cmd && (byte_idx < ent_amt);
  assign type_hs  = in_cmd && tx_type_rdy_i;
  assign data_hs  = data_vld && tx_data_rdy_i;

`ifdef DBI_INIT_AUTO_START_EN
  logic auto_pend;

  // Armed by reset, consumed on the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) auto_pend <= 1'b1;
    else     auto_pend <= 1'b0;
  end

  assign start_go = start_i || auto_pend;
`else
  assign start_go = start_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ent_idx  <= 3'd0;
      byte_idx <= 3'd0;
      slp_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_go) begin
            state    <= ST_CMD;
            ent_idx  <= 3'd0;
            byte_idx <= 3'd0;
          end
        end
        ST_CMD: begin
          // Type acceptance closes the entry even if it coincides with a data beat.
          if (type_hs) begin
            byte_idx <= 3'd0;
            if (ent_idx == SLP_ENT) begin
              state   <= ST_SLP_WAIT;
              slp_cnt <= SLP_LOAD;
            end else if (ent_idx == LAST_ENT) begin
              state <= ST_DONE;
            end else begin
              ent_idx <= ent_idx + 3'd1;
            end
          end else if (data_hs) begin
            byte_idx <= byte_idx + 3'd1;
          end
        end
        ST_SLP_WAIT: begin
          if (slp_cnt == '0) begin
            state    <= ST_CMD;
            ent_idx  <= POST_SLP_ENT;
            byte_idx <= 3'd0;
          end else begin
            slp_cnt <= slp_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (start_i) begin
            state    <= ST_CMD;
            ent_idx  <= 3'd0;
            byte_idx <= 3'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbi_ctrl_mode_o   = (state == ST_IDLE) ? 2'd0 :
                             (state == ST_DONE) ? 2'd2 : 2'd1;
  assign dbi_mem_com_o     = DBI_IF_D_W'(8'h2C);
  assign tx_type_rw_o      = 1'b0;
  assign tx_type_hrst_o    = in_cmd && ent_hrst;
  assign tx_type_dat_amt_o = in_cmd ? ent_amt : 3'd0;
  assign tx_type_vld_o     = in_cmd;
  assign tx_com_o          = in_cmd ? DBI_IF_D_W'(ent_com) : '0;
  assign tx_com_vld_o      = in_cmd && !ent_hrst;
  assign tx_data_o         = data_vld ? DBI_IF_D_W'(ent_byte) : '0;
  assign tx_data_vld_o     = data_vld;
  assign busy_o            = (state == ST_CMD) || (state == ST_SLP_WAIT);
  assign done_o            = (state == ST_DONE);

  // Command-accept strobe and clock rate carry no behaviour here.
  logic unused_ok;
  assign unused_ok = tx_com_rdy_i ^ (INTERNAL_CLK != 0);

endmodule

// File: tb/tb_dbi_init_seq.sv
// tb/tb_dbi_init_seq.sv - Randomized self-checking bench for dbi_init_seq against a transaction-level model.
module tb_dbi_init_seq;

  localparam int SLP = 16;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic       tx_type_rdy_i;
  logic       tx_com_rdy_i;
  logic       tx_data_rdy_i;
  logic [1:0] dbi_ctrl_mode_o;
  logic [7:0] dbi_mem_com_o;
  logic       tx_type_rw_o;
  logic       tx_type_hrst_o;
  logic [2:0] tx_type_dat_amt_o;
  logic       tx_type_vld_o;
  logic [7:0] tx_com_o;
  logic       tx_com_vld_o;
  logic [7:0] tx_data_o;
  logic       tx_data_vld_o;
  logic       busy_o;
  logic       done_o;

  dbi_init_seq #(
    .INTERNAL_CLK (125000000),
    .DBI_IF_D_W   (8),
    .SLP_WAIT_CYC (SLP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start_i           (start_i),
    .tx_type_rdy_i     (tx_type_rdy_i),
    .tx_com_rdy_i      (tx_com_rdy_i),
    .tx_data_rdy_i     (tx_data_rdy_i),
    .dbi_ctrl_mode_o   (dbi_ctrl_mode_o),
    .dbi_mem_com_o     (dbi_mem_com_o),
    .tx_type_rw_o      (tx_type_rw_o),
    .tx_type_hrst_o    (tx_type_hrst_o),
    .tx_type_dat_amt_o (tx_type_dat_amt_o),
    .tx_type_vld_o     (tx_type_vld_o),
    .tx_com_o          (tx_com_o),
    .tx_com_vld_o      (tx_com_vld_o),
    .tx_data_o         (tx_data_o),
    .tx_data_vld_o     (tx_data_vld_o),
    .busy_o            (busy_o),
    .done_o            (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the init table as data, progress as (phase, entry, bytes sent, wait left).
  int         m_com  [7] = '{0, 'h11, 'h3A, 'h36, 'h2A, 'h2B, 'h29};
  int         m_amt  [7] = '{0, 0, 1, 1, 4, 4, 0};
  bit         m_hrst [7] = '{1, 0, 0, 0, 0, 0, 0};
  logic [7:0] m_data [7][4];

  int phase;      // 0 idle, 1 cmd, 2 sleep wait, 3 done
  int ent;
  int nb;
  int wait_left;
  bit auto_pend;

  int         rdy_mode;   // 0 none, 1 all, 2 random, 3 E4 paced pattern
  int         e4_cnt;
  int         wait_obs;
  logic [7:0] e4_got[$];

  function automatic logic [35:0] exp_vec();
    logic [1:0] md;
    logic       tv, cv, hr, dv;
    logic [2:0] amt;
    logic [7:0] com, dat;
    md = (phase == 0) ? 2'd0 : (phase == 3) ? 2'd2 : 2'd1;
    tv = 0; cv = 0; hr = 0; dv = 0; amt = 0; com = 0; dat = 0;
    if (phase == 1) begin
      tv  = 1;
      hr  = m_hrst[ent];
      cv  = !hr;
      amt = 3'(m_amt[ent]);
      com = 8'(m_com[ent]);
      dv  = (nb < m_amt[ent]);
      dat = dv ? m_data[ent][nb] : 8'h00;
    end
    return {md, 1'(phase == 1 || phase == 2), 1'(phase == 3), tv, cv, hr, 1'b0,
            amt, com, dv, dat, 8'h2C};
  endfunction

  function automatic logic [35:0] dut_vec();
    return {dbi_ctrl_mode_o, busy_o, done_o, tx_type_vld_o, tx_com_vld_o, tx_type_hrst_o,
            tx_type_rw_o, tx_type_dat_amt_o, tx_com_o, tx_data_vld_o, tx_data_o, dbi_mem_com_o};
  endfunction

  task automatic model_step();
    bit go;
    if (rst) begin
      phase = 0; ent = 0; nb = 0; auto_pend = 1;
    end else begin
`ifdef DBI_INIT_AUTO_START_EN
      go = start_i || auto_pend;
`else
      go = start_i;
`endif
      auto_pend = 0;
      case (phase)
        0: if (go) begin phase = 1; ent = 0; nb = 0; end
        1: begin
          if (tx_type_rdy_i) begin
            nb = 0;
            if (ent == 1)      begin phase = 2; wait_left = SLP; end
            else if (ent == 6) phase = 3;
            else               ent++;
          end else if (nb < m_amt[ent] && tx_data_rdy_i) begin
            nb++;
          end
        end
        2: begin
          wait_left--;
          if (wait_left == 0) begin phase = 1; ent = 2; nb = 0; end
        end
        default: if (start_i) begin phase = 1; ent = 0; nb = 0; end
      endcase
    end
  endtask

  task automatic tick();
    case (rdy_mode)
      0: begin tx_type_rdy_i = 0; tx_data_rdy_i = 0; tx_com_rdy_i = 0; end
      1: begin tx_type_rdy_i = 1; tx_data_rdy_i = 1; tx_com_rdy_i = 1; end
      2: begin
        tx_data_rdy_i = 1'($urandom_range(0, 1));
        tx_type_rdy_i = ($urandom_range(0, 3) == 0);
        tx_com_rdy_i  = 1'($urandom_range(0, 1));
      end
      default: begin
        if (phase == 1 && ent == 4) begin
          e4_cnt++;
          tx_data_rdy_i = (e4_cnt % 3 == 0);
          tx_type_rdy_i = tx_data_rdy_i && (nb == 3);
          tx_com_rdy_i  = 1;
        end else begin
          tx_type_rdy_i = 1; tx_data_rdy_i = 1; tx_com_rdy_i = 1;
        end
      end
    endcase
    @(negedge clk);
    check("cyc", 64'(dut_vec()), 64'(exp_vec()));
    if (tx_data_vld_o && tx_data_rdy_i && phase == 1 && ent == 4) e4_got.push_back(tx_data_o);
    if (!rst && dbi_ctrl_mode_o == 2'd1 && !tx_type_vld_o) wait_obs++;
    @(posedge clk);
    model_step();
    #1;
    start_i = 0;
  endtask

  task automatic run_until(input int ph, input int en, input int budget, input string tag);
    bit hit;
    hit = 0;
    for (int k = 0; k < budget; k++) begin
      if (phase == ph && (en < 0 || ent == en)) begin hit = 1; break; end
      tick();
    end
    if (phase == ph && (en < 0 || ent == en)) hit = 1;
    check(tag, 64'(hit), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 4; j++)
        m_data[i][j] = 8'h00;
    m_data[2][0] = 8'h55;
    m_data[3][0] = 8'h48;
    m_data[4][3] = 8'hEF;
    m_data[5][2] = 8'h01;
    m_data[5][3] = 8'h3F;
    phase = 0; ent = 0; nb = 0; wait_left = 0; auto_pend = 1;
    rdy_mode = 0; e4_cnt = 0; wait_obs = 0;

    rst = 1; start_i = 0; tx_type_rdy_i = 0; tx_com_rdy_i = 0; tx_data_rdy_i = 0;
    repeat (3) tick();
    check("rst_mode", 64'(dbi_ctrl_mode_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_vld", 64'({tx_type_vld_o, tx_com_vld_o, tx_data_vld_o}), 64'd0);
    rst = 0;

`ifdef DBI_INIT_AUTO_START_EN
    tick();
    tick();
    check("auto_e0_vld", 64'({tx_type_vld_o, tx_type_hrst_o}), 64'h3);
`endif

    // Full sequence with every rdy asserted.
    rdy_mode = 1; start_i = 1; wait_obs = 0;
    tick();
    run_until(3, -1, 200, "s1_reach_done");
    check("s1_done", 64'(done_o), 64'd1);
    check("s1_mode", 64'(dbi_ctrl_mode_o), 64'd2);
    check("s1_slp_cycles", 64'(wait_obs), 64'(SLP));

    // Restart from DONE, then random back-pressure with ignored start pulses.
    rdy_mode = 0; start_i = 1;
    tick();
    check("s2_mode", 64'(dbi_ctrl_mode_o), 64'd1);
    check("s2_busy", 64'(busy_o), 64'd1);
    check("s2_e0", 64'({tx_type_vld_o, tx_type_hrst_o, tx_com_vld_o}), 64'h6);
    rdy_mode = 2;
    for (int k = 0; k < 3000 && phase != 3; k++) begin
      start_i = ($urandom_range(0, 7) == 0);
      tick();
    end
    check("s2_done", 64'(done_o), 64'd1);

    // Stall E3 for 50 cycles, then pace E4 at one byte every 3 cycles.
    rdy_mode = 1; start_i = 1;
    tick();
    run_until(1, 3, 200, "s3_reach_e3");
    rdy_mode = 0;
    repeat (50) tick();
    check("s3_hold_vld", 64'(tx_type_vld_o), 64'd1);
    check("s3_hold_com", 64'(tx_com_o), 64'h36);
    check("s3_hold_data", 64'(tx_data_o), 64'h48);
    rdy_mode = 3; e4_cnt = 0; e4_got.delete();
    run_until(1, 5, 100, "s3_reach_e5");
    check("s3_e4_count", 64'(e4_got.size()), 64'd4);
    if (e4_got.size() == 4) begin
      check("s3_e4_b0", 64'(e4_got[0]), 64'h00);
      check("s3_e4_b1", 64'(e4_got[1]), 64'h00);
      check("s3_e4_b2", 64'(e4_got[2]), 64'h00);
      check("s3_e4_b3", 64'(e4_got[3]), 64'hEF);
    end
    rdy_mode = 1;
    run_until(3, -1, 200, "s3_reach_done");

    // Reset mid sleep-wait (internal count 7 == 8 cycles left), then restart.
    start_i = 1;
    tick();
    for (int k = 0; k < 200 && !(phase == 2 && wait_left == 8); k++) tick();
    check("s4_in_wait", 64'(busy_o && !tx_type_vld_o), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    check("s4_mode", 64'(dbi_ctrl_mode_o), 64'd0);
    check("s4_vld", 64'({tx_type_vld_o, tx_com_vld_o, tx_data_vld_o}), 64'd0);
    start_i = 1;
    tick();
    check("s4_restart_e0", 64'({tx_type_vld_o, tx_type_hrst_o}), 64'h3);
    run_until(3, -1, 200, "s4_reach_done");
    check("s4_done", 64'(done_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
